// File: rtl/calc_sequencer_if.sv
// ----------------------------------------------------------------------------
// calc_sequencer_if
//   Groups the three buses of the calculator sequencer into one bundle:
//     cmd_*  : command stream into the sequencer (valid/ready, 11-bit payload)
//     rsp_*  : result stream out of the sequencer (valid/ready, 4-bit result)
//     calc_* : drive/read port of the external 4-register calculator
//   Modports:
//     slave  : the sequencer side (accepts commands, drives the calculator)
//     master : the environment side (issues commands, models the calculator)
// ----------------------------------------------------------------------------
interface calc_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_data;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_data;

  logic        calc_clk;
  logic [1:0]  calc_rd_addr;
  logic [1:0]  calc_we_addr;
  logic [2:0]  calc_control;
  logic [3:0]  calc_imm;
  logic [3:0]  calc_rd_data;

  modport slave (
    input  cmd_valid, cmd_data, rsp_ready, calc_rd_data,
    output cmd_ready, rsp_valid, rsp_data,
    output calc_clk, calc_rd_addr, calc_we_addr, calc_control, calc_imm
  );

  modport master (
    output cmd_valid, cmd_data, rsp_ready, calc_rd_data,
    input  cmd_ready, rsp_valid, rsp_data,
    input  calc_clk, calc_rd_addr, calc_we_addr, calc_control, calc_imm
  );
endinterface

// File: rtl/calc_sequencer.sv
// ----------------------------------------------------------------------------
// calc_sequencer
//   Queues calculator commands and plays each one out to an external
//   calculator as a single clean calc_clk pulse, then reads back the written
//   register and returns it on the response stream.
//
//   Per command: DRIVE (pop + latch fields) -> PULSE (calc_clk high)
//   -> COMMIT (calc_clk low, calculator writes) -> READ (read back we_addr)
//   -> RESP (hold result until rsp_ready).
//
//   Ports:
//     clk      : single clock, all state on posedge
//     rst_n    : asynchronous active-low reset
//     bus      : calc_sequencer_if.slave (cmd_*, rsp_*, calc_* signals)
//     busy     : FSM not IDLE or queue not empty
//     ops_done : count of completed responses, wraps at 255
//   Parameter:
//     FIFO_DEPTH : command queue depth, 2/4/8/16
// ----------------------------------------------------------------------------
module calc_sequencer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  calc_sequencer_if.slave       bus,
  output logic                  busy,
  output logic [7:0]            ops_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0] rd_addr;
    logic [1:0] we_addr;
    logic [2:0] control;
    logic [3:0] imm;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE, DRIVE, PULSE, COMMIT, READ, RESP
  } state_t;

  state_t           state, state_next;
  cmd_t             mem [FIFO_DEPTH];
  cmd_t             head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             push, pop, rsp_fire;

  logic             cmd_ready_q, rsp_valid_q, calc_clk_q;
  logic [3:0]       rsp_data_q;
  logic [1:0]       calc_rd_addr_q, calc_we_addr_q;
  logic [2:0]       calc_control_q;
  logic [3:0]       calc_imm_q;

  // cmd_ready is registered and already 0 when full, so a push can never
  // land on a full queue, even in a cycle that also pops.
  assign push     = bus.cmd_valid && cmd_ready_q;
  assign rsp_fire = (state == RESP) && bus.rsp_ready;
  // The queue is popped exactly on entry to DRIVE (DRIVE lasts one cycle).
  assign pop      = (state_next == DRIVE);
  assign head     = mem[rd_ptr];

  assign count_next = count + CNT_W'(push) - CNT_W'(pop);

  // NOTE: queue storage has no reset; the pointers and count decide which
  // entries are valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.cmd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path through it leaves state_next unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0) state_next = DRIVE;
      DRIVE:   state_next = PULSE;
      PULSE:   state_next = COMMIT;
      COMMIT:  state_next = READ;
      READ:    state_next = RESP;
      RESP:    if (bus.rsp_ready) state_next = (count != '0) ? DRIVE : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs are flops decoded from state_next, so calc_clk and the
  // handshake signals change only on clk and never glitch.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      cmd_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      calc_clk_q     <= 1'b0;
      calc_rd_addr_q <= '0;
      calc_we_addr_q <= '0;
      calc_control_q <= '0;
      calc_imm_q     <= '0;
      ops_done       <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count_next;
      cmd_ready_q <= (count_next != CNT_W'(FIFO_DEPTH));
      calc_clk_q  <= (state_next == PULSE);
      rsp_valid_q <= (state_next == RESP);

      if (pop) begin
        calc_rd_addr_q <= head.rd_addr;
        calc_we_addr_q <= head.we_addr;
        calc_control_q <= head.control;
        calc_imm_q     <= head.imm;
      end else if (state_next == READ) begin
        // Read back the register just written; the write already happened
        // on the calc_clk falling edge at the start of COMMIT.
        calc_rd_addr_q <= calc_we_addr_q;
      end

      if (state == READ) rsp_data_q <= bus.calc_rd_data;
      if (rsp_fire)      ops_done   <= ops_done + 8'd1;
    end
  end

  assign busy             = (state != IDLE) || (count != '0);
  assign bus.cmd_ready    = cmd_ready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.calc_clk     = calc_clk_q;
  assign bus.calc_rd_addr = calc_rd_addr_q;
  assign bus.calc_we_addr = calc_we_addr_q;
  assign bus.calc_control = calc_control_q;
  assign bus.calc_imm     = calc_imm_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_calc_sequencer
//   Directed bench for calc_sequencer. Includes a behavioural model of the
//   4x4-bit calculator (writes on calc_clk falling edge, combinational read).
// ----------------------------------------------------------------------------
module tb_calc_sequencer;

  localparam int DEPTH = 4;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] ops_done;

  calc_sequencer_if bus ();

  calc_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .ops_done (ops_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Calculator model: register file is never reset by the sequencer.
  logic [3:0] regs [4];

  function automatic logic [3:0] alu(input logic [3:0] a, input logic [2:0] op,
                                     input logic [3:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return 4'd0;
    endcase
  endfunction

  always @(negedge bus.calc_clk)
    regs[bus.calc_we_addr] <= alu(regs[bus.calc_rd_addr], bus.calc_control, bus.calc_imm);

  assign bus.calc_rd_data = regs[bus.calc_rd_addr];

  int rises = 0;
  int falls = 0;
  int cyc   = 0;
  always @(posedge bus.calc_clk) rises++;
  always @(negedge bus.calc_clk) falls++;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] mk(input logic [1:0] rd, input logic [1:0] we,
                                     input logic [2:0] op, input logic [3:0] imm);
    return {rd, we, op, imm};
  endfunction

  logic [10:0] cmds [8];
  logic [3:0]  exps [8];
  int          acc_cyc [8];
  int          rsp_cyc [8];
  int          idx;
  int          got;

  // Offers cmds[idx..] and consumes responses until both goals are met or
  // the cycle budget runs out. Responses are compared in order to exps[].
  task automatic drive_until(input int cmd_goal, input int rsp_goal, input int budget);
    int         guard;
    int         pre_cyc;
    logic       acc;
    logic       fire;
    logic [3:0] d;
    guard = 0;
    while ((idx < cmd_goal || got < rsp_goal) && guard < budget) begin
      if (idx < cmd_goal) begin
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = cmds[idx];
      end else begin
        bus.cmd_valid = 1'b0;
      end
      acc     = bus.cmd_ready && (idx < cmd_goal);
      fire    = bus.rsp_valid && bus.rsp_ready;
      d       = bus.rsp_data;
      pre_cyc = cyc;
      tick();
      guard++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      if (fire) begin
        rsp_cyc[got] = pre_cyc;
        check($sformatf("rsp%0d_data", got), 32'(d), 32'(exps[got]));
        got++;
      end
    end
    bus.cmd_valid = 1'b0;
    check("progress_within_budget", 32'(idx >= cmd_goal && got >= rsp_goal), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [4:0] clk_pat;
  logic [4:0] vld_pat;

  initial begin
    for (int i = 0; i < 4; i++) regs[i] = 4'd0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // ---------------- reset values ----------------
    tick();
    tick();
    check("rst_cmd_ready",    32'(bus.cmd_ready),    32'd0);
    check("rst_rsp_valid",    32'(bus.rsp_valid),    32'd0);
    check("rst_rsp_data",     32'(bus.rsp_data),     32'd0);
    check("rst_calc_clk",     32'(bus.calc_clk),     32'd0);
    check("rst_calc_rd_addr", 32'(bus.calc_rd_addr), 32'd0);
    check("rst_calc_we_addr", 32'(bus.calc_we_addr), 32'd0);
    check("rst_calc_control", 32'(bus.calc_control), 32'd0);
    check("rst_calc_imm",     32'(bus.calc_imm),     32'd0);
    check("rst_busy",         32'(busy),             32'd0);
    check("rst_ops_done",     32'(ops_done),         32'd0);
    rst_n = 1'b1;
    check("ready_before_first_edge", 32'(bus.cmd_ready), 32'd0);
    tick();
    check("ready_after_first_edge", 32'(bus.cmd_ready), 32'd1);

    // ---------------- single command, per-cycle timing ----------------
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(2'd0, 2'd1, OP_ADD, 4'd5);
    tick();                                   // edge k: accepted
    bus.cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy), 32'd1);
    clk_pat = 5'b00010;                       // edges k+1..k+5: DRIVE PULSE COMMIT READ RESP
    vld_pat = 5'b10000;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("s1_calc_clk_%0d", i),  32'(bus.calc_clk),  32'(clk_pat[i]));
      check($sformatf("s1_rsp_valid_%0d", i), 32'(bus.rsp_valid), 32'(vld_pat[i]));
      if (i == 3) check("s1_read_addr", 32'(bus.calc_rd_addr), 32'd1);
    end
    check("s1_rsp_data",          32'(bus.rsp_data), 32'd5);
    check("s1_ops_before_hshake", 32'(ops_done),     32'd0);
    tick();                                   // RESP handshake
    check("s1_valid_after_hshake", 32'(bus.rsp_valid), 32'd0);
    check("s1_ops_done",           32'(ops_done),      32'd1);
    check("s1_busy_idle",          32'(busy),          32'd0);

    // ---------------- back-to-back commands ----------------
    idx = 0; got = 0;
    cmds[0] = mk(2'd1, 2'd1, OP_ADD, 4'd3); exps[0] = 4'd8;
    cmds[1] = mk(2'd1, 2'd2, OP_SUB, 4'd2); exps[1] = 4'd6;
    cmds[2] = mk(2'd1, 2'd3, OP_ADD, 4'd9); exps[2] = 4'd1;
    drive_until(3, 3, 40);
    check("s2_latency",  32'(rsp_cyc[0] - acc_cyc[0]), 32'd5);
    check("s2_spacing1", 32'(rsp_cyc[1] - rsp_cyc[0]), 32'd5);
    check("s2_spacing2", 32'(rsp_cyc[2] - rsp_cyc[1]), 32'd5);
    tick();
    check("s2_ops_done", 32'(ops_done), 32'd4);
    check("s2_pulses",   32'(rises),    32'd4);
    check("s2_falls",    32'(falls),    32'd4);

    // ---------------- fill the queue with rsp_ready low ----------------
    // regs now: r0=0 r1=8 r2=6 r3=1
    bus.rsp_ready = 1'b0;
    idx = 0; got = 0;
    cmds[0] = mk(2'd2, 2'd0, OP_OR,  4'h1); exps[0] = 4'h7;  // 6|1
    cmds[1] = mk(2'd0, 2'd1, OP_AND, 4'hC); exps[1] = 4'h4;  // 7&C
    cmds[2] = mk(2'd1, 2'd2, OP_SLT, 4'h5); exps[2] = 4'h1;  // 4<5
    cmds[3] = mk(2'd3, 2'd3, OP_SUB, 4'h3); exps[3] = 4'hE;  // 1-3
    cmds[4] = mk(2'd3, 2'd0, OP_ADD, 4'h2); exps[4] = 4'h0;  // E+2
    cmds[5] = mk(2'd2, 2'd1, OP_ADD, 4'hA); exps[5] = 4'hB;  // 1+A
    drive_until(DEPTH + 1, 0, 5);
    check("s3_full_ready", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = cmds[5];
    for (int i = 0; i < 8; i++) begin
      tick();
      check($sformatf("s3_ready_low_%0d", i), 32'(bus.cmd_ready), 32'd0);
      if (i >= 1) check($sformatf("s3_rsp_stable_%0d", i), 32'(bus.rsp_data), 32'h7);
    end
    check("s3_rsp_valid_held", 32'(bus.rsp_valid), 32'd1);
    check("s3_ops_held",       32'(ops_done),      32'd4);
    bus.rsp_ready = 1'b1;
    drive_until(DEPTH + 2, DEPTH + 2, 80);
    for (int i = 0; i < 10; i++) tick();
    check("s3_no_extra_rsp", 32'(bus.rsp_valid), 32'd0);
    check("s3_ops_done",     32'(ops_done),      32'd10);
    check("s3_busy",         32'(busy),          32'd0);
    check("s3_pulses",       32'(rises),         32'd10);
    check("s3_falls",        32'(falls),         32'd10);

    // ---------------- reset while in READ ----------------
    // regs now: r0=0 r1=B r2=1 r3=E
    check("s4_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = mk(2'd1, 2'd2, OP_ADD, 4'h1);            // B+1 -> r2=C
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("s4_in_read_addr", 32'(bus.calc_rd_addr), 32'd2);
    check("s4_in_read_rdat", 32'(bus.calc_rd_data), 32'hC);
    rst_n = 1'b0;
    #1;
    check("s4_rst_rsp_valid", 32'(bus.rsp_valid),    32'd0);
    check("s4_rst_rsp_data",  32'(bus.rsp_data),     32'd0);
    check("s4_rst_cmd_ready", 32'(bus.cmd_ready),    32'd0);
    check("s4_rst_rd_addr",   32'(bus.calc_rd_addr), 32'd0);
    check("s4_rst_we_addr",   32'(bus.calc_we_addr), 32'd0);
    check("s4_rst_control",   32'(bus.calc_control), 32'd0);
    check("s4_rst_imm",       32'(bus.calc_imm),     32'd0);
    check("s4_rst_busy",      32'(busy),             32'd0);
    check("s4_rst_ops_done",  32'(ops_done),         32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s4_ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    check("s4_reg_kept",        32'(regs[2]),       32'hC);
    check("s4_no_report",       32'(bus.rsp_valid), 32'd0);
    idx = 0; got = 0;
    cmds[0] = mk(2'd2, 2'd3, OP_SUB, 4'h4); exps[0] = 4'h8;  // C-4
    drive_until(1, 1, 20);
    check("s4_ops_restart", 32'(ops_done), 32'd1);
    for (int i = 0; i < 5; i++) tick();
    check("s4_idle_pulses", 32'(rises), 32'd12);
    check("s4_idle_falls",  32'(falls), 32'd12);
    check("s4_idle_busy",   32'(busy),  32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, command queue depth; legal values 2, 4, 8 and 16.
REQ-002 The block SHALL have clk, input, 1 bit: the single clock; all state updates on posedge clk.
REQ-003 The block SHALL have rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have cmd_valid, input, 1 bit: command offered.
REQ-005 The block SHALL have cmd_ready, output, 1 bit: queue not full (registered).
REQ-006 The block SHALL have cmd_data, input, 11 bits: {rd_addr[10:9], we_addr[8:7], control[6:4], imm[3:0]}.
REQ-007 The block SHALL have rsp_valid, output, 1 bit: result available.
REQ-008 The block SHALL have rsp_ready, input, 1 bit: result consumed.
REQ-009 The block SHALL have rsp_data, output, 4 bits: value written to register we_addr.
REQ-010 The block SHALL have calc_clk, output, 1 bit: calculator clock; the calculator commits its write on the falling edge of calc_clk.
REQ-011 The block SHALL have calc_rd_addr, output, 2 bits: calculator read address.
REQ-012 The block SHALL have calc_we_addr, output, 2 bits: calculator write address.
REQ-013 The block SHALL have calc_control, output, 3 bits: ALU op; 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-014 The block SHALL have calc_imm, output, 4 bits: ALU immediate operand.
REQ-015 The block SHALL have calc_rd_data, input, 4 bits: calculator read port.
REQ-016 The block SHALL have busy, output, 1 bit: FSM not IDLE or queue not empty.
REQ-017 The block SHALL have ops_done, output, 8 bits: count of completed responses.

Function
REQ-018 A command SHALL be accepted on a posedge where cmd_valid and cmd_ready are both 1; accepted commands SHALL be executed in FIFO order.
REQ-019 cmd_ready SHALL be 0 when FIFO_DEPTH entries are held; a push and a pop in the same cycle while full SHALL NOT be accepted.
REQ-020 The FSM SHALL have the states IDLE, DRIVE, PULSE, COMMIT, READ and RESP, with one state per clk cycle except IDLE and RESP.
REQ-021 IDLE SHALL move to DRIVE when the queue is non-empty; IDLE SHALL otherwise hold.
REQ-022 On entry to DRIVE, the head entry SHALL be popped and calc_rd_addr, calc_we_addr, calc_control and calc_imm SHALL be latched; calc_clk SHALL be 0.
REQ-023 PULSE SHALL drive calc_clk = 1 with all calc_* fields held.
REQ-024 COMMIT SHALL drive calc_clk = 0, and this falling edge SHALL be the only write to the calculator for the command; calc_we_addr and calc_imm SHALL be held stable.
REQ-025 READ SHALL drive calc_rd_addr = latched we_addr, and rsp_data SHALL capture calc_rd_data at the end of READ.
REQ-026 RESP SHALL drive rsp_valid = 1 and hold rsp_data stable until rsp_ready = 1.
REQ-027 On the RESP handshake, ops_done SHALL increment by 1, wrapping 255 -> 0; the FSM SHALL then go to DRIVE if the queue is non-empty and to IDLE otherwise.
REQ-028 Latency SHALL be: a command accepted at edge k into an idle, empty block produces rsp_valid = 1 after edge k+5; back-to-back throughput is 1 command per 5 cycles when rsp_ready = 1.
REQ-029 calc_clk SHALL be driven from a flop, never from combinational logic, and SHALL be glitch-free.
REQ-030 Arithmetic SHALL be 4-bit modulo 16, as performed by the calculator; the block SHALL NOT modify the result.
REQ-031 rsp_ready asserted while rsp_valid = 0 SHALL be ignored.

Reset
REQ-032 While rst_n = 0, outputs SHALL be: cmd_ready 0, rsp_valid 0, rsp_data 0, calc_clk 0, calc_* fields 0, busy 0, ops_done 0, FSM IDLE, queue empty.
REQ-033 After rst_n rises, cmd_ready SHALL go to 1 on the first posedge.
REQ-034 The calculator register contents SHALL NOT be reset by this block.
REQ-035 Reset asserted during PULSE forces calc_clk low, which commits that write; the in-flight command SHALL NOT be reported and SHALL NOT be counted.

Verification
REQ-036 From reset, push {rd 0, we 1, ADD, imm 5} -> rsp_data 5 after edge k+5; ops_done = 1.
REQ-037 Then push {rd 1, we 1, ADD, 3}, {rd 1, we 2, SUB, 2} and {rd 1, we 3, ADD, 9} back-to-back -> responses 8, 6, 1 (wrap), in that order, 5 cycles apart.
REQ-038 Hold rsp_ready = 0 and push FIFO_DEPTH+1 commands -> cmd_ready drops to 0 at the full point, no command is lost, and rsp_data stays stable.
REQ-039 Sample calc_clk on every cycle -> exactly one 0->1->0 pulse per command and none while idle.
REQ-040 Assert rst_n = 0 in READ -> all outputs take reset values immediately; the next command executes normally and ops_done restarts from 0.
